// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI master clocking path and its consumers
// (sclk_edge_gen, the downstream mode adapter and the slave side).
//   sclk_state_e          : serial-clock generator state encoding
//   cpol(mode)            : clock polarity bit of an SPI mode (0..3)
//   cpha(mode)            : clock phase bit of an SPI mode (0..3)
//   half_cnt_width(n)     : counter width for a modulo-n half-period timer
// ---------------------------------------------------------------------------
package spi_pkg;

  // Smallest legal number of clk cycles per SCLK half-period.
  localparam int MIN_CLKS_PER_HALF_BIT = 32'sd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sclk_state_e;

  function automatic logic cpol(input int spi_mode);
    return spi_mode[1];
  endfunction

  function automatic logic cpha(input int spi_mode);
    return spi_mode[0];
  endfunction

  // Illegal divisors are rejected at elaboration by the generator, so the
  // 1-bit fallback only keeps declarations well formed until that error fires.
  function automatic int half_cnt_width(input int n);
    return (n < MIN_CLKS_PER_HALF_BIT) ? 32'sd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sclk_half_timer.sv
// ---------------------------------------------------------------------------
// sclk_half_timer
// Modulo-CLKS_PER_HALF_BIT counter that paces the SCLK half-periods.
//   clk  in  : system clock
//   rst  in  : asynchronous active-high reset
//   clr  in  : synchronous clear to 0 (wins over en)
//   en   in  : advance the count this cycle
//   tc   out : count is at its terminal value (CLKS_PER_HALF_BIT-1)
// ---------------------------------------------------------------------------
module sclk_half_timer
  import spi_pkg::*;
#(
  parameter int CLKS_PER_HALF_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = half_cnt_width(CLKS_PER_HALF_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_HALF_BIT - 32'sd1);
  localparam logic [CW-1:0] ONE  = CW'(32'sd1);

  logic [CW-1:0] cnt_r;

  // Half-period count: wraps at the terminal value, clear has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (en) begin
      if (cnt_r == LAST) begin
        cnt_r <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + ONE;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tc = (cnt_r == LAST);

endmodule

// File: rtl/sclk_edge_gen.sv
// ---------------------------------------------------------------------------
// sclk_edge_gen
// SPI master serial-clock generator. Divides clk into SCLK (half-period of
// CLKS_PER_HALF_BIT clk cycles) and emits one-cycle strobes registered in the
// same edge as each SCLK transition. Stopping always lets SCLK finish back at
// its idle level (CPOL).
//   clk     in  : system clock
//   rst     in  : asynchronous active-high reset
//   en      in  : run request (level)
//   clear_d in  : synchronous abort, shared with the mode adapter
//   sclk    out : generated serial clock (registered)
//   r_edge  out : strobe in the cycle sclk goes 0->1 (registered)
//   f_edge  out : strobe in the cycle sclk goes 1->0 (registered)
//   idle_v  out : constant ~CPOL
//   busy    out : generator is not idle (registered)
// ---------------------------------------------------------------------------
module sclk_edge_gen
  import spi_pkg::*;
#(
  parameter int SPI_MODE          = 3,
  parameter int CLKS_PER_HALF_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear_d,
  output logic sclk,
  output logic r_edge,
  output logic f_edge,
  output logic idle_v,
  output logic busy
);

  localparam logic CPOL = cpol(SPI_MODE);

  if (CLKS_PER_HALF_BIT < MIN_CLKS_PER_HALF_BIT) begin : g_half_bit_check
    $error("sclk_edge_gen: CLKS_PER_HALF_BIT must be at least 2");
  end

  sclk_state_e state_r;
  logic        sclk_r;
  logic        r_edge_r;
  logic        f_edge_r;
  logic        busy_r;

  logic        active_s;
  logic        stop_s;
  logic        tmr_clr_s;
  logic        tmr_en_s;
  logic        tc_s;

  // Timer control: count only while running/draining; an immediate stop
  // (SCLK already at idle level) drops the partial half-period so the next
  // start begins a full half-period.
  always_comb begin
    active_s  = 1'b0;
    stop_s    = 1'b0;
    tmr_clr_s = 1'b1;
    tmr_en_s  = 1'b0;
    if (state_r != IDLE) begin
      active_s = 1'b1;
    end else begin
      active_s = 1'b0;
    end
    if (active_s && !en && (sclk_r == CPOL)) begin
      stop_s = 1'b1;
    end else begin
      stop_s = 1'b0;
    end
    tmr_clr_s = clear_d || !active_s || stop_s;
    tmr_en_s  = active_s;
  end

  sclk_half_timer #(
    .CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT)
  ) u_half_timer (
    .clk(clk),
    .rst(rst),
    .clr(tmr_clr_s),
    .en (tmr_en_s),
    .tc (tc_s)
  );

  // Generator FSM with SCLK, strobe and busy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      sclk_r   <= CPOL;
      r_edge_r <= 1'b0;
      f_edge_r <= 1'b0;
      busy_r   <= 1'b0;
    end else if (clear_d) begin
      state_r  <= IDLE;
      sclk_r   <= CPOL;
      r_edge_r <= 1'b0;
      f_edge_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          sclk_r   <= CPOL;
          r_edge_r <= 1'b0;
          f_edge_r <= 1'b0;
          if (en) begin
            state_r <= RUN;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        RUN, DRAIN: begin
          if (stop_s) begin
            // SCLK already rests at CPOL: stop without a further edge.
            state_r  <= IDLE;
            sclk_r   <= sclk_r;
            r_edge_r <= 1'b0;
            f_edge_r <= 1'b0;
            busy_r   <= 1'b0;
          end else if (tc_s) begin
            sclk_r   <= ~sclk_r;
            r_edge_r <= ~sclk_r;
            f_edge_r <= sclk_r;
            if (en) begin
              state_r <= RUN;
              busy_r  <= 1'b1;
            end else if (~sclk_r == CPOL) begin
              // This toggle lands SCLK on its idle level: done.
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end else begin
              state_r <= DRAIN;
              busy_r  <= 1'b1;
            end
          end else begin
            sclk_r   <= sclk_r;
            r_edge_r <= 1'b0;
            f_edge_r <= 1'b0;
            busy_r   <= 1'b1;
            if (en) begin
              state_r <= RUN;
            end else begin
              state_r <= DRAIN;
            end
          end
        end
        default: begin
          state_r  <= IDLE;
          sclk_r   <= CPOL;
          r_edge_r <= 1'b0;
          f_edge_r <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  assign sclk   = sclk_r;
  assign r_edge = r_edge_r;
  assign f_edge = f_edge_r;
  assign busy   = busy_r;
  assign idle_v = ~CPOL;

endmodule

// File: tb/tb_sclk_edge_gen.sv
// ---------------------------------------------------------------------------
// tb_sclk_edge_gen
// Four generator instances (mode0/N4, mode3/N4, mode2/N4, mode1/N2) sharing
// one clock. Expected strobes are pushed to a scoreboard as the stimulus is
// driven; the monitor pops and compares them as the selected DUT strobes.
// ---------------------------------------------------------------------------
module tb_sclk_edge_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rst_v  = 4'hF;
  logic [3:0] en_v   = 4'h0;
  logic [3:0] clr_v  = 4'h0;
  logic [3:0] sclk_v;
  logic [3:0] r_v;
  logic [3:0] f_v;
  logic [3:0] idlev_v;
  logic [3:0] busy_v;

  // CPOL per instance: [0]=mode0, [1]=mode3, [2]=mode2, [3]=mode1
  localparam logic [3:0] CPOL_V = 4'b0110;

  sclk_edge_gen #(.SPI_MODE(0), .CLKS_PER_HALF_BIT(4)) u_m0 (
    .clk(clk), .rst(rst_v[0]), .en(en_v[0]), .clear_d(clr_v[0]),
    .sclk(sclk_v[0]), .r_edge(r_v[0]), .f_edge(f_v[0]),
    .idle_v(idlev_v[0]), .busy(busy_v[0]));

  sclk_edge_gen #(.SPI_MODE(3), .CLKS_PER_HALF_BIT(4)) u_m3 (
    .clk(clk), .rst(rst_v[1]), .en(en_v[1]), .clear_d(clr_v[1]),
    .sclk(sclk_v[1]), .r_edge(r_v[1]), .f_edge(f_v[1]),
    .idle_v(idlev_v[1]), .busy(busy_v[1]));

  sclk_edge_gen #(.SPI_MODE(2), .CLKS_PER_HALF_BIT(4)) u_m2 (
    .clk(clk), .rst(rst_v[2]), .en(en_v[2]), .clear_d(clr_v[2]),
    .sclk(sclk_v[2]), .r_edge(r_v[2]), .f_edge(f_v[2]),
    .idle_v(idlev_v[2]), .busy(busy_v[2]));

  sclk_edge_gen #(.SPI_MODE(1), .CLKS_PER_HALF_BIT(2)) u_m1 (
    .clk(clk), .rst(rst_v[3]), .en(en_v[3]), .clear_d(clr_v[3]),
    .sclk(sclk_v[3]), .r_edge(r_v[3]), .f_edge(f_v[3]),
    .idle_v(idlev_v[3]), .busy(busy_v[3]));

  typedef struct {
    int cyc;
    bit rise;
  } ev_t;

  ev_t sb[$];
  int  cyc    = 0;
  int  errors = 0;
  int  checks = 0;
  int  sel    = 0;

  // Number of posedges elapsed; an event "at edge e" is seen at the negedge
  // where cyc == e.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_ev(input int at, input bit rise);
    ev_t e;
    e.cyc  = at;
    e.rise = rise;
    sb.push_back(e);
  endtask

  // Monitor the selected DUT for n negedges, matching strobes to the scoreboard.
  task automatic watch(input int n);
    ev_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        checks++; errors++;
        $display("FAIL missed_strobe: nothing at edge %0d, required rise=%0b", e.cyc, e.rise);
      end
      checks++;
      if ((r_v[sel] & f_v[sel]) !== 1'b0) begin
        errors++;
        $display("FAIL both_strobes: dut%0d r=%b f=%b at edge %0d, required not both", sel, r_v[sel], f_v[sel], cyc);
      end
      if (r_v[sel] === 1'b1 || f_v[sel] === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: dut%0d r=%b f=%b at edge %0d, required none", sel, r_v[sel], f_v[sel], cyc);
        end else begin
          e = sb.pop_front();
          if (e.cyc !== cyc || e.rise !== r_v[sel]) begin
            errors++;
            $display("FAIL strobe_event: dut%0d edge %0d rise=%b, required edge %0d rise=%0b", sel, cyc, r_v[sel], e.cyc, e.rise);
          end
        end
        checks++;
        if (sclk_v[sel] !== r_v[sel]) begin
          errors++;
          $display("FAIL strobe_sclk: dut%0d sclk=%b with r=%b, required sclk=%b", sel, sclk_v[sel], r_v[sel], r_v[sel]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_v = 4'hF; en_v = 4'h0; clr_v = 4'h0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sclk_v[i] !== CPOL_V[i]) begin errors++; $display("FAIL reset_sclk: dut%0d got %b, required %b", i, sclk_v[i], CPOL_V[i]); end
      checks++;
      if (r_v[i] !== 1'b0 || f_v[i] !== 1'b0) begin errors++; $display("FAIL reset_strobes: dut%0d got r=%b f=%b, required 0 0", i, r_v[i], f_v[i]); end
      checks++;
      if (busy_v[i] !== 1'b0) begin errors++; $display("FAIL reset_busy: dut%0d got %b, required 0", i, busy_v[i]); end
      checks++;
      if (idlev_v[i] !== ~CPOL_V[i]) begin errors++; $display("FAIL idle_v: dut%0d got %b, required %b", i, idlev_v[i], ~CPOL_V[i]); end
    end
    rst_v = 4'h0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sclk_v[i] !== CPOL_V[i] || busy_v[i] !== 1'b0) begin
        errors++; $display("FAIL post_reset_idle: dut%0d got sclk=%b busy=%b, required %b 0", i, sclk_v[i], busy_v[i], CPOL_V[i]);
      end
    end
  endtask

  // Mode 0, N=4: en held 64 cycles -> 8 r_edge / 8 f_edge, 4 cycles apart.
  task automatic test_mode0_run();
    int k;
    sel = 0;
    k = cyc + 1;
    en_v[0] = 1'b1;
    for (int m = 1; m <= 16; m++) push_ev(k + 4 * m, (m % 2) == 1);
    watch(1);
    checks++;
    if (busy_v[0] !== 1'b1 || sclk_v[0] !== 1'b0) begin errors++; $display("FAIL m0_start: busy=%b sclk=%b, required 1 0", busy_v[0], sclk_v[0]); end
    watch(63);
    en_v[0] = 1'b0;
    watch(1);
    checks++;
    if (busy_v[0] !== 1'b0 || sclk_v[0] !== 1'b0) begin errors++; $display("FAIL m0_stop: busy=%b sclk=%b, required 0 0", busy_v[0], sclk_v[0]); end
    watch(10);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL m0_leftover: %0d strobes not seen, required 0", sb.size()); end
    sb.delete();
  endtask

  // Mode 3, N=4: idles high, first strobe f_edge, period 8.
  task automatic test_mode3();
    int k;
    sel = 1;
    k = cyc + 1;
    en_v[1] = 1'b1;
    push_ev(k + 4, 1'b0); push_ev(k + 8, 1'b1); push_ev(k + 12, 1'b0); push_ev(k + 16, 1'b1);
    watch(1);
    checks++;
    if (busy_v[1] !== 1'b1 || sclk_v[1] !== 1'b1) begin errors++; $display("FAIL m3_start: busy=%b sclk=%b, required 1 1", busy_v[1], sclk_v[1]); end
    watch(15);
    en_v[1] = 1'b0;
    watch(1);
    checks++;
    if (busy_v[1] !== 1'b0 || sclk_v[1] !== 1'b1) begin errors++; $display("FAIL m3_stop: busy=%b sclk=%b, required 0 1", busy_v[1], sclk_v[1]); end
    watch(8);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL m3_leftover: %0d strobes not seen, required 0", sb.size()); end
    sb.delete();
  endtask

  // Mode 0: en dropped 2 cycles into the high phase -> drain with one f_edge.
  task automatic test_drain();
    int k;
    sel = 0;
    k = cyc + 1;
    en_v[0] = 1'b1;
    push_ev(k + 4, 1'b1); push_ev(k + 8, 1'b0);
    watch(6);
    en_v[0] = 1'b0;
    watch(1);
    checks++;
    if (busy_v[0] !== 1'b1 || sclk_v[0] !== 1'b1) begin errors++; $display("FAIL drain_hold: busy=%b sclk=%b, required 1 1", busy_v[0], sclk_v[0]); end
    watch(2);
    checks++;
    if (busy_v[0] !== 1'b0 || sclk_v[0] !== 1'b0) begin errors++; $display("FAIL drain_end: busy=%b sclk=%b, required 0 0", busy_v[0], sclk_v[0]); end
    watch(8);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL drain_leftover: %0d strobes not seen, required 0", sb.size()); end
    sb.delete();
  endtask

  // Mode 0: en dropped while sclk=0 -> immediate stop, then a clean restart.
  task automatic test_stop_low();
    int k;
    sel = 0;
    en_v[0] = 1'b1;
    watch(2);
    en_v[0] = 1'b0;
    watch(1);
    checks++;
    if (busy_v[0] !== 1'b0 || sclk_v[0] !== 1'b0) begin errors++; $display("FAIL stop_low: busy=%b sclk=%b, required 0 0", busy_v[0], sclk_v[0]); end
    k = cyc + 1;
    en_v[0] = 1'b1;
    push_ev(k + 4, 1'b1); push_ev(k + 8, 1'b0);
    watch(5);
    en_v[0] = 1'b0;
    watch(6);
    checks++;
    if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL restart_stop: busy=%b, required 0", busy_v[0]); end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL restart_leftover: %0d strobes not seen, required 0", sb.size()); end
    sb.delete();
  endtask

  // Mode 2: clear_d on a terminal count, then en+clear_d together.
  task automatic test_clear_tc();
    int k;
    sel = 2;
    en_v[2] = 1'b1;
    watch(4);
    clr_v[2] = 1'b1;
    watch(1);
    checks++;
    if (busy_v[2] !== 1'b0 || sclk_v[2] !== 1'b1) begin errors++; $display("FAIL clear_tc: busy=%b sclk=%b, required 0 1", busy_v[2], sclk_v[2]); end
    clr_v[2] = 1'b0;
    en_v[2]  = 1'b0;
    watch(4);
    en_v[2]  = 1'b1;
    clr_v[2] = 1'b1;
    watch(1);
    checks++;
    if (busy_v[2] !== 1'b0) begin errors++; $display("FAIL clear_en_hold: busy=%b, required 0", busy_v[2]); end
    clr_v[2] = 1'b0;
    k = cyc + 1;
    push_ev(k + 4, 1'b0); push_ev(k + 8, 1'b1);
    watch(1);
    checks++;
    if (busy_v[2] !== 1'b1) begin errors++; $display("FAIL clear_en_start: busy=%b, required 1", busy_v[2]); end
    watch(7);
    en_v[2] = 1'b0;
    watch(1);
    checks++;
    if (busy_v[2] !== 1'b0 || sclk_v[2] !== 1'b1) begin errors++; $display("FAIL clear_en_stop: busy=%b sclk=%b, required 0 1", busy_v[2], sclk_v[2]); end
    watch(4);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL clear_leftover: %0d strobes not seen, required 0", sb.size()); end
    sb.delete();
  endtask

  // Mode 1, N=2: asynchronous reset during the high phase, then restart.
  task automatic test_reset_mid();
    int k;
    sel = 3;
    k = cyc + 1;
    en_v[3] = 1'b1;
    push_ev(k + 2, 1'b1); push_ev(k + 4, 1'b0); push_ev(k + 6, 1'b1);
    watch(7);
    #2;
    rst_v[3] = 1'b1;
    en_v[3]  = 1'b0;
    #1;
    checks++;
    if (sclk_v[3] !== 1'b0) begin errors++; $display("FAIL async_rst_sclk: got %b, required 0", sclk_v[3]); end
    checks++;
    if (r_v[3] !== 1'b0 || f_v[3] !== 1'b0) begin errors++; $display("FAIL async_rst_strobes: r=%b f=%b, required 0 0", r_v[3], f_v[3]); end
    checks++;
    if (busy_v[3] !== 1'b0) begin errors++; $display("FAIL async_rst_busy: got %b, required 0", busy_v[3]); end
    @(negedge clk);
    rst_v[3] = 1'b0;
    k = cyc + 1;
    en_v[3] = 1'b1;
    push_ev(k + 2, 1'b1); push_ev(k + 4, 1'b0);
    watch(3);
    en_v[3] = 1'b0;
    watch(5);
    checks++;
    if (busy_v[3] !== 1'b0 || sclk_v[3] !== 1'b0) begin errors++; $display("FAIL n2_stop: busy=%b sclk=%b, required 0 0", busy_v[3], sclk_v[3]); end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL n2_leftover: %0d strobes not seen, required 0", sb.size()); end
    sb.delete();
  endtask

  initial begin
    test_reset();
    test_mode0_run();
    test_mode3();
    test_drain();
    test_stop_low();
    test_clear_tc();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sclk_edge_gen.md
# sclk_edge_gen

SPI master serial-clock generator, directly upstream of the mode adapter stage. It divides the system clock into SCLK and emits one-cycle rising/falling edge strobes aligned to each SCLK transition. The adapter consumes `sclk`, `r_edge`, `f_edge` and `idle_v`, and is cleared with the same `clear_d`. Start/stop is driven by the master FSM through `en`.

## Interface
- `SPI_MODE`, default 3: SPI mode 0..3. CPOL = `SPI_MODE[1]`.
- `CLKS_PER_HALF_BIT`, default 4: `clk` cycles per SCLK half-period. Legal range ≥2; a value <2 is an elaboration error.
- `clk` in, 1: system clock; all state changes on posedge.
- `rst` in, 1: reset, asynchronous, active-high.
- `en` in, 1: run request from the master FSM; level-sensitive.
- `clear_d` in, 1: synchronous abort; shared with the downstream adapter.
- `sclk` out, 1, registered: generated serial clock.
- `r_edge` out, 1, registered: one-cycle strobe in the cycle `sclk` goes 0→1.
- `f_edge` out, 1, registered: one-cycle strobe in the cycle `sclk` goes 1→0.
- `idle_v` out, 1, constant: equals ~CPOL. Downstream idles SCLK at ~`idle_v`.
- `busy` out, 1, registered: high whenever state ≠ IDLE.

## Operation
- States:
  - IDLE: `sclk`=CPOL, counter=0, no strobes.
  - RUN: free-running toggle.
  - DRAIN: finishing the half-period that returns SCLK to CPOL.
- Half-period counter, width `$clog2(CLKS_PER_HALF_BIT)`:
  - Counts 0..`CLKS_PER_HALF_BIT`-1 in RUN/DRAIN.
  - At terminal count: wraps to 0, `sclk` toggles, exactly one of `r_edge`/`f_edge` is set per the new `sclk` value.
  - In all other cycles both strobes are 0.
- Transitions:
  - IDLE→RUN when `en`=1.
  - RUN→IDLE when `en`=0 and `sclk`==CPOL. Counter clears; no strobe.
  - RUN→DRAIN when `en`=0 and `sclk`≠CPOL.
  - DRAIN→IDLE on the terminal count. That cycle's toggle is performed with its strobe, so `sclk` ends at CPOL.
  - DRAIN→RUN if `en` re-asserts before the terminal count. The counter continues without restart.
- The first edge out of IDLE is always away from CPOL: `r_edge` for modes 0/1, `f_edge` for modes 2/3. Strobes strictly alternate.
- Priority order: `rst` > `clear_d` > FSM logic.
- `clear_d`=1 forces, at the next clk edge:
  - state IDLE, counter 0, `sclk`=CPOL;
  - `r_edge`=`f_edge`=0, `busy`=0.
  - `clear_d` wins over a simultaneous terminal count or `en`.
- `en` and `clear_d` both high: the block holds IDLE for that cycle and starts on the next cycle if `en` is still 1.
- `r_edge` and `f_edge` are never high together.
- No edge counting: the downstream adapter owns edge counting and end-of-transfer detection.

## Timing
- Reset values:
  - `sclk`=CPOL, `r_edge`=0, `f_edge`=0, `busy`=0;
  - state IDLE, counter 0.
  - `idle_v` is a constant and unaffected by reset.
- `en` sampled high at edge k: `busy`=1 after edge k. First toggle and strobe are visible after edge k+`CLKS_PER_HALF_BIT`.
- SCLK period is 2×`CLKS_PER_HALF_BIT` clk cycles. Duty cycle is exactly 50%.
- Strobe and `sclk` change are registered in the same clk edge. Latency from counter terminal value to outputs is 0 extra cycles.
- Stop latency:
  - `sclk`==CPOL: `busy` falls 1 cycle after `en` is seen low.
  - Otherwise: `busy` falls on the DRAIN terminal edge, at most `CLKS_PER_HALF_BIT` cycles after `en` is seen low.
- Reset asserted mid-run: outputs go to reset values immediately, asynchronously. No partial strobe survives.

## Structure
- Shared package `spi_pkg`:
  - state enum (IDLE, RUN, DRAIN);
  - function `cpol(SPI_MODE)`;
  - function `cpha(SPI_MODE)`, for use by the adapter and slave side.
- Single natural sub-module: `sclk_half_timer`, a parameterised modulo-`CLKS_PER_HALF_BIT` counter with `clr`/`en` inputs and a `tc` output.
- The FSM and output registers stay in `sclk_edge_gen`.

## Test plan
- Mode 0, N=4, `en` held 64 cycles:
  - first `r_edge` 4 cycles after `en` sampled;
  - strobes every 4 cycles, alternating;
  - exactly 8 `r_edge` and 8 `f_edge`;
  - `idle_v`=1, `sclk` idles 0.
- Mode 3, N=4:
  - `sclk` resets to 1, `idle_v`=0;
  - first strobe is `f_edge`, then `r_edge`; period 8 cycles.
- Mode 0, N=4, `en` dropped 2 cycles into a high phase:
  - one `f_edge` 2 cycles later, `sclk`=0;
  - `busy`=0 after that edge; no further strobes.
- Mode 0, N=4, `en` dropped while `sclk`=0:
  - `busy`=0 one cycle later;
  - no strobe; the counter restarts from 0 on the next `en`.
- `clear_d` pulsed in the same cycle as a terminal count (mode 2):
  - no strobe that cycle;
  - `sclk`=1 (CPOL) next cycle, `busy`=0.
- N=2 (minimum), mode 1, `rst` asserted mid high phase:
  - before reset: period 4 cycles;
  - on reset: `sclk`=0 and strobes 0 immediately, asynchronously;
  - after release: restart yields the first `r_edge` 2 cycles after `en`.
